// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, constants and helpers for the UART transmitter
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } uart_tx_state_t;

  localparam logic UART_IDLE_LVL = 1'b1;

  function automatic int uart_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_rise.sv
`default_nettype none
// ============================================================================
// Module      : edge_rise
// Description : Single-cycle pulse on each rising edge of a level input
// Revision    : 1.0 - initial release
// ============================================================================
module edge_rise (
  input  logic clk,
  input  logic rst_,
  input  logic in,
  output logic pulse
);

  logic in_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  assign pulse = in & ~in_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_cke.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cke
// Description : UART frame transmitter paced by the rising edge of a bit-rate
//               enable level. Define UART_TX_PARITY_EN to add an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cke
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              cke,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy
);

  localparam int              CNT_W     = uart_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  uart_tx_state_t    state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] shift_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stop_q, stop_d;
  logic              tx_q, tx_d;
  logic              tick;

  edge_rise u_edge (
    .clk   (clk),
    .rst_  (rst_),
    .in    (cke),
    .pulse (tick)
  );

`ifdef UART_TX_PARITY_EN
  // Parity is captured at accept because the shift register is consumed.
  logic par_q, par_d;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= UART_IDLE_LVL;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
    end
  end

  assign shift_nxt = shift_q >> 1;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = UART_IDLE_LVL;
        if (valid) begin
          shift_d = data;
          state_d = SYNC;
`ifdef UART_TX_PARITY_EN
          par_d   = ^data;
`endif
        end
      end
      SYNC: if (tick) begin
        tx_d    = 1'b0;
        state_d = START;
      end
      START: if (tick) begin
        tx_d    = shift_q[0];
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: if (tick) begin
        if (cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
          tx_d    = par_q;
          state_d = PARITY;
`else
          tx_d    = UART_IDLE_LVL;
          stop_d  = 1'b0;
          state_d = STOP;
`endif
        end else begin
          shift_d = shift_nxt;
          cnt_d   = cnt_q + 1'b1;
          tx_d    = shift_nxt[0];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) begin
        tx_d    = UART_IDLE_LVL;
        stop_d  = 1'b0;
        state_d = STOP;
      end
`endif
      STOP: if (tick) begin
        if (stop_q == STOP_LAST) begin
          state_d = IDLE;
        end else begin
          stop_d = stop_q + 1'b1;
        end
      end
      default: begin
        tx_d    = UART_IDLE_LVL;
        state_d = IDLE;
      end
    endcase
  end

  assign ready = (state_q == IDLE);
  assign busy  = ~ready;
  assign tx    = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cke.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_cke
// Description : Self-checking bench for uart_tx_cke with a frame-level model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cke;

  localparam int DW  = 8;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB  = 1;
`else
  localparam int PB  = 0;
`endif
  localparam int FL  = 1 + DW + PB + SB;
  localparam int PER = 16;
  localparam int HI  = 9;

  logic          clk   = 1'b0;
  logic          rst_  = 1'b0;
  logic          cke   = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] data  = '0;
  logic          ready, tx, busy;

  uart_tx_cke #(.DATA_W(DW), .STOP_BITS(SB)) dut (
    .clk   (clk),
    .rst_  (rst_),
    .cke   (cke),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // cke: mode 0 = periodic (16 clk, 9 high), mode 1 = held high
  int cke_mode = 0;
  int ph       = PER - 1;
  initial forever begin
    @(posedge clk);
    #1;
    ph  = (ph + 1) % PER;
    cke = (cke_mode == 0) ? (ph < HI) : 1'b1;
  end

  // Reference model: the expected line value of period k of a frame
  function automatic logic frame_bit(input logic [DW-1:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return w[k-1];
    if (PB == 1 && k == DW + 1) return ^w;
    return 1'b1;
  endfunction

  function automatic int frame_transitions(input logic [DW-1:0] w);
    int   n  = 0;
    logic pv = 1'b1;
    for (int k = 0; k < FL; k++) begin
      if (frame_bit(w, k) != pv) n++;
      pv = frame_bit(w, k);
    end
    return n;
  endfunction

  logic [DW-1:0] exp_q[$];
  bit            mon_en   = 1'b1;
  bit            mon_busy = 1'b0;
  logic          mon_prev = 1'b1;
  int            tx_changes = 0;
  logic          chg_prev   = 1'b1;

  initial forever begin
    step();
    if (tx !== chg_prev) tx_changes++;
    chg_prev = tx;
  end

  // Frame monitor: every period value and its full hold, then ready timing
  initial forever begin
    step();
    if (mon_en && mon_prev && !tx) begin
      logic [DW-1:0] w;
      check("frame expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        mon_busy = 1'b1;
        for (int k = 0; k < FL; k++) begin
          check($sformatf("w%02h bit%0d first", w, k), tx, frame_bit(w, k));
          repeat (PER - 1) step();
          check($sformatf("w%02h bit%0d hold", w, k), tx, frame_bit(w, k));
          if (k == FL - 1) check("ready before stop end", ready, 0);
          step();
        end
        check("ready after stop", ready, 1);
        mon_busy = 1'b0;
      end
    end
    mon_prev = tx;
  end

  task automatic send(input logic [DW-1:0] w, input bit push, input bit keep);
    int g = 0;
    data  = w;
    valid = 1'b1;
    while (!ready && g < 400) begin
      step();
      g++;
    end
    check("accept timeout", g < 400, 1);
    if (push) exp_q.push_back(w);
    step();
    if (!keep) valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((!ready || mon_busy || exp_q.size() != 0) && g < 5000) begin
      step();
      g++;
    end
    check("idle timeout", g < 5000, 1);
  endtask

  task automatic wait_tx_low();
    int g = 0;
    while (tx && g < 200) begin
      step();
      g++;
    end
    check("start bit timeout", g < 200, 1);
  endtask

  initial begin
    int n;
    int c0;
    int c1;

    repeat (3) @(posedge clk);
    #2;
    check("reset tx", tx, 1);
    check("reset ready", ready, 1);
    check("reset busy", busy, 0);
    rst_ = 1'b1;
    repeat (3) step();

    // Directed frames, including the parity examples
    send(8'hA5, 1, 0);
    wait_idle();
    send(8'h07, 1, 0);
    wait_idle();

    // Back-to-back with valid held high
    send(8'h55, 1, 1);
    send(8'h0F, 1, 0);
    wait_idle();

    // Accept in the same cycle as a tick: start bit one full period later
    n = 0;
    while (ph != 0 && n < 40) begin
      step();
      n++;
    end
    data  = 8'h3C;
    valid = 1'b1;
    exp_q.push_back(8'h3C);
    step();
    valid = 1'b0;
    n = 0;
    while (tx && n < 100) begin
      step();
      n++;
    end
    check("start delay after tick accept", n, PER);
    wait_idle();

    // cke stuck high for 100 clk mid-frame: exactly one advance
    mon_en = 1'b0;
    c0 = tx_changes;
    send(8'h55, 0, 0);
    wait_tx_low();
    repeat (3 * PER) step();
    n = 0;
    while (ph != 10 && n < 40) begin
      step();
      n++;
    end
    cke_mode = 1;
    c1 = tx_changes;
    repeat (100) step();
    check("advances while cke high", tx_changes - c1, 1);
    cke_mode = 0;
    wait_idle();
    check("stalled frame transitions", tx_changes - c0, frame_transitions(8'h55));

    // Asynchronous reset during data bit 3 of 0xFF
    send(8'hFF, 0, 0);
    wait_tx_low();
    repeat (4 * PER + 5) step();
    #1;
    rst_ = 1'b0;
    #1;
    check("mid-frame reset tx", tx, 1);
    check("mid-frame reset ready", ready, 1);
    check("mid-frame reset busy", busy, 0);
    step();
    step();
    rst_ = 1'b1;
    repeat (3) step();
    mon_en = 1'b1;
    send(8'h12, 1, 0);
    wait_idle();

    // Randomized words, gaps and held-valid runs
    for (int i = 0; i < 25; i++) begin
      logic [DW-1:0] w;
      bit            keep;
      w    = DW'($urandom);
      keep = 1'($urandom_range(0, 1));
      send(w, 1, keep);
      if (!keep) repeat ($urandom_range(0, 40)) step();
    end
    valid = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
